// File: rtl/tetris_pkg.sv
// Shared board geometry, cell encoding and piece-dropper state encoding.
// Consumers: drop_collision_check, piece_dropper, piece_dropper_if.
package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int CELLS   = BOARD_W * BOARD_H;
    localparam int AW      = 8;
    localparam int DW      = 8;

    localparam logic [DW-1:0] EMPTY_CELL = '0;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        ERASE,
        WRITE,
        DONE
    } drop_state_t;

    // One extra bit so a target below the last row never wraps back onto the board.
    typedef logic [AW:0] tgt_addr_t;

    function automatic tgt_addr_t below(input logic [AW-1:0] a);
        return {1'b0, a} + tgt_addr_t'(BOARD_W);
    endfunction

endpackage

// File: rtl/piece_dropper_if.sv
// Placer/control/board-memory signals of the piece dropper.
// DROPPER_HARD_DROP_EN adds the hard_drop request bit.
interface piece_dropper_if;
    import tetris_pkg::*;

    logic          load;
    logic [AW-1:0] reg_1_addr;
    logic [AW-1:0] reg_2_addr;
    logic [AW-1:0] reg_3_addr;
    logic [AW-1:0] reg_4_addr;
    logic [DW-1:0] piece_data;
    logic          en;
    logic          busy;
    logic          done;
    logic          landed;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [AW-1:0] cur_1_addr;
    logic [AW-1:0] cur_2_addr;
    logic [AW-1:0] cur_3_addr;
    logic [AW-1:0] cur_4_addr;
`ifdef DROPPER_HARD_DROP_EN
    logic          hard_drop;
`endif

    modport slave (
        input  load, reg_1_addr, reg_2_addr, reg_3_addr, reg_4_addr, piece_data, en, rdata,
        output busy, done, landed, we, addr, wdata,
               cur_1_addr, cur_2_addr, cur_3_addr, cur_4_addr
`ifdef DROPPER_HARD_DROP_EN
        , input hard_drop
`endif
    );

    modport master (
        output load, reg_1_addr, reg_2_addr, reg_3_addr, reg_4_addr, piece_data, en, rdata,
        input  busy, done, landed, we, addr, wdata,
               cur_1_addr, cur_2_addr, cur_3_addr, cur_4_addr
`ifdef DROPPER_HARD_DROP_EN
        , output hard_drop
`endif
    );

endinterface

// File: rtl/drop_collision_check.sv
// Combinational collision helper: which targets are the piece's own cells,
// whether any target falls off the bottom, and whether the read cell is filled.
module drop_collision_check
    import tetris_pkg::*;
(
    input  tgt_addr_t [3:0]         tgt,
    input  logic      [3:0][AW-1:0] cur,
    input  logic      [DW-1:0]      rdata,
    output logic      [3:0]         own_mask,
    output logic                    bottom,
    output logic                    filled
);

    logic [3:0] past_floor;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cell
            logic [3:0] hit;
            for (genvar gj = 0; gj < 4; gj++) begin : g_cmp
                assign hit[gj] = (tgt[gi] == {1'b0, cur[gj]});
            end
            assign own_mask[gi]   = |hit;
            assign past_floor[gi] = (tgt[gi] >= tgt_addr_t'(CELLS));
        end
    endgenerate

    assign bottom = |past_floor;
    assign filled = (rdata != EMPTY_CELL);

endmodule

// File: rtl/piece_dropper.sv
// Gravity stage: moves the last placed piece down one row per en, or reports landing.
// DROPPER_HARD_DROP_EN: hard_drop keeps stepping until the piece lands.
module piece_dropper
    import tetris_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    piece_dropper_if.slave bus
);

    drop_state_t state_reg, state_next;
    logic [1:0]  idx_reg, idx_next;
    logic        landed_reg, landed_next;

    logic [3:0][AW-1:0] cur_reg;
    logic [3:0][AW-1:0] load_addr;
    logic [DW-1:0]      color_reg;
    logic               piece_valid_reg;
    logic [2:0]         occ_reg;

    tgt_addr_t [3:0] tgt;
    logic [AW-1:0]   tgt_sel;
    logic [3:0]      own_mask;
    logic            bottom, filled, occ_now, any_occ, start, last;
    logic [1:0]      rd_sel;

    assign load_addr = {bus.reg_4_addr, bus.reg_3_addr, bus.reg_2_addr, bus.reg_1_addr};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_tgt
            assign tgt[gi] = below(cur_reg[gi]);
        end
    endgenerate

    drop_collision_check u_check (
        .tgt      (tgt),
        .cur      (cur_reg),
        .rdata    (bus.rdata),
        .own_mask (own_mask),
        .bottom   (bottom),
        .filled   (filled)
    );

    // rdata always belongs to the address driven one cycle earlier.
    assign rd_sel  = (state_reg == CHECK) ? 2'd3 : idx_reg - 2'd1;
    assign occ_now = filled && !own_mask[rd_sel];
    assign any_occ = (|occ_reg) || occ_now;
    assign start   = bus.en && piece_valid_reg && !bus.load;
    assign last    = (idx_reg == 2'd3);
    assign tgt_sel = tgt[idx_reg][AW-1:0];

`ifdef DROPPER_HARD_DROP_EN
    logic            hard_reg;
    logic            hd_bottom;
    tgt_addr_t [3:0] hd_tgt;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hd
            assign hd_tgt[gi] = below(tgt[gi][AW-1:0]);
        end
    endgenerate

    always_comb begin
        hd_bottom = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (hd_tgt[k] >= tgt_addr_t'(CELLS)) hd_bottom = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            landed_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            landed_reg <= landed_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        landed_next = landed_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = bottom ? DONE : READ;
                    landed_next = bottom;
                end
            end
            READ:  if (last) state_next = CHECK;
            CHECK: begin
                state_next  = any_occ ? DONE : ERASE;
                landed_next = any_occ;
            end
            ERASE: if (last) state_next = WRITE;
            WRITE: begin
                if (last) begin
`ifdef DROPPER_HARD_DROP_EN
                    // Hard drop re-enters the step check on the already-moved piece.
                    if (hard_reg && !hd_bottom) begin
                        state_next = READ;
                    end else begin
                        state_next  = DONE;
                        landed_next = hard_reg;
                    end
`else
                    state_next  = DONE;
                    landed_next = 1'b0;
`endif
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        idx_next = (state_next != state_reg) ? 2'd0 : idx_reg + 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_reg         <= '0;
            color_reg       <= '0;
            piece_valid_reg <= 1'b0;
            occ_reg         <= '0;
`ifdef DROPPER_HARD_DROP_EN
            hard_reg        <= 1'b0;
`endif
        end else begin
            if (state_reg == IDLE && bus.load) begin
                cur_reg         <= load_addr;
                color_reg       <= bus.piece_data;
                piece_valid_reg <= 1'b1;
            end
`ifdef DROPPER_HARD_DROP_EN
            if (state_reg == IDLE && start) hard_reg <= bus.hard_drop;
`endif
            if (state_reg == READ && idx_reg != 2'd0) occ_reg[rd_sel] <= occ_now;
            if (state_reg == WRITE && last) begin
                for (int k = 0; k < 4; k++) cur_reg[k] <= tgt[k][AW-1:0];
            end
            if (state_reg == DONE && landed_reg) piece_valid_reg <= 1'b0;
        end
    end

    always_comb begin
        bus.busy   = (state_reg != IDLE);
        bus.done   = (state_reg == DONE);
        bus.landed = (state_reg == DONE) && landed_reg;
        bus.we     = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        case (state_reg)
            READ:  bus.addr = tgt_sel;
            ERASE: begin
                bus.we    = 1'b1;
                bus.addr  = cur_reg[idx_reg];
                bus.wdata = EMPTY_CELL;
            end
            WRITE: begin
                bus.we    = 1'b1;
                bus.addr  = tgt_sel;
                bus.wdata = color_reg;
            end
            default: ;
        endcase
    end

    assign bus.cur_1_addr = cur_reg[0];
    assign bus.cur_2_addr = cur_reg[1];
    assign bus.cur_3_addr = cur_reg[2];
    assign bus.cur_4_addr = cur_reg[3];

endmodule

// File: tb/tb_piece_dropper.sv
// Randomized self-checking bench for piece_dropper against a board-level gravity model.
// Hard-drop scenarios run when DROPPER_HARD_DROP_EN is defined.
module tb_piece_dropper;
    import tetris_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    piece_dropper_if bus();

    piece_dropper dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Board memory with synchronous read; the bench has its own preload port.
    logic [DW-1:0] mem [0:255];
    logic          tb_clear = 1'b0;
    logic          tb_we = 1'b0;
    logic [AW-1:0] tb_waddr = '0;
    logic [DW-1:0] tb_wdata = '0;

    always @(posedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (tb_we) begin
            mem[tb_waddr] <= tb_wdata;
        end else if (bus.we) begin
            mem[bus.addr] <= bus.wdata;
        end
        bus.rdata <= mem[bus.addr];
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:255];
    int            ref_cur [4];
    logic [DW-1:0] ref_color;
    bit            ref_valid;
    int            exp_reads[$];
    int            obs_reads[$];

    int checks = 0;
    int failures = 0;

    int offs [7][4] = '{'{0, 1, 10, 11}, '{0, 10, 20, 30}, '{0, 1, 2, 3},
                        '{0, 1, 2, 11}, '{1, 2, 10, 11}, '{0, 1, 11, 12}, '{0, 10, 20, 21}};
    int wid  [7]    = '{2, 1, 4, 3, 3, 3, 2};

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_board;
        tb_clear = 1'b1;
        tick();
        tb_clear = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    endtask

    task automatic tb_put(input int a, input logic [DW-1:0] d);
        tb_we = 1'b1;
        tb_waddr = AW'(a);
        tb_wdata = d;
        tick();
        tb_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic place(input int c0, input int c1, input int c2, input int c3,
                         input logic [DW-1:0] col);
        tb_put(c0, col); tb_put(c1, col); tb_put(c2, col); tb_put(c3, col);
        bus.reg_1_addr = AW'(c0);
        bus.reg_2_addr = AW'(c1);
        bus.reg_3_addr = AW'(c2);
        bus.reg_4_addr = AW'(c3);
        bus.piece_data = col;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        ref_cur = '{c0, c1, c2, c3};
        ref_color = col;
        ref_valid = 1'b1;
    endtask

    // Gravity rules on the whole board: latency counts the en cycle as cycle 1.
    task automatic model_step(input bit hd, output int lat, output bit landed, output int nwr);
        int  t [4];
        bit  off_board, blocked, own;
        lat = 1;
        landed = 1'b0;
        nwr = 0;
        forever begin
            off_board = 1'b0;
            for (int k = 0; k < 4; k++) begin
                t[k] = ref_cur[k] + BOARD_W;
                if (t[k] >= CELLS) off_board = 1'b1;
            end
            if (off_board) begin
                lat += 1;
                landed = 1'b1;
                break;
            end
            for (int k = 0; k < 4; k++) exp_reads.push_back(t[k]);
            blocked = 1'b0;
            for (int k = 0; k < 4; k++) begin
                own = 1'b0;
                for (int j = 0; j < 4; j++) if (t[k] == ref_cur[j]) own = 1'b1;
                if (ref_mem[t[k]] != 0 && !own) blocked = 1'b1;
            end
            if (blocked) begin
                lat += 6;
                landed = 1'b1;
                break;
            end
            for (int k = 0; k < 4; k++) ref_mem[ref_cur[k]] = '0;
            for (int k = 0; k < 4; k++) ref_mem[t[k]] = ref_color;
            for (int k = 0; k < 4; k++) ref_cur[k] = t[k];
            nwr += 8;
            lat += 13;
            if (!hd) begin
                lat += 1;
                break;
            end
        end
        if (landed) ref_valid = 1'b0;
    endtask

    task automatic run_step(input bit hd, input bit junk, input string tag);
        int exp_lat, exp_nwr, lat, nwr, bad_at;
        bit exp_landed, got_done, got_landed, was_valid, busy_seen;
        was_valid = ref_valid;
        exp_reads.delete();
        obs_reads.delete();
        exp_lat = 0; exp_nwr = 0; exp_landed = 1'b0;
        if (was_valid) model_step(hd, exp_lat, exp_landed, exp_nwr);
        bus.en = 1'b1;
`ifdef DROPPER_HARD_DROP_EN
        bus.hard_drop = hd;
`endif
        tick();
        bus.en = 1'b0;
        if (!was_valid) begin
            busy_seen = 1'b0;
            repeat (20) begin
                if (bus.busy || bus.we) busy_seen = 1'b1;
                tick();
            end
            checks++;
            if (busy_seen !== 1'b0) begin
                failures++;
                $display("FAIL %s ignored_en: activity=%0b expected 0", tag, busy_seen);
            end
            return;
        end
        got_done = 1'b0; got_landed = 1'b0; lat = 0; nwr = 0;
        for (int c = 2; c <= 400 && !got_done; c++) begin
            if (junk && c == 4) begin
                bus.reg_1_addr = AW'($urandom_range(0, 199));
                bus.reg_2_addr = AW'($urandom_range(0, 199));
                bus.load = 1'b1;
                bus.en = 1'b1;
            end else if (junk && c == 5) begin
                bus.load = 1'b0;
                bus.en = 1'b0;
            end
            if (bus.busy && !bus.we && !bus.done && bus.addr != 0) obs_reads.push_back(int'(bus.addr));
            if (bus.we) nwr++;
            if (bus.done) begin
                got_done = 1'b1;
                lat = c;
                got_landed = bus.landed;
            end else begin
                tick();
            end
        end
        bus.load = 1'b0;
        bus.en = 1'b0;
        checks++;
        if (!got_done) begin
            failures++;
            $display("FAIL %s done_timeout: no done within 400 cycles", tag);
        end
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
        end
        checks++;
        if (got_landed !== exp_landed) begin
            failures++;
            $display("FAIL %s landed: got %0b expected %0b", tag, got_landed, exp_landed);
        end
        checks++;
        if (nwr !== exp_nwr) begin
            failures++;
            $display("FAIL %s write_count: got %0d expected %0d", tag, nwr, exp_nwr);
        end
        bad_at = -1;
        if (obs_reads.size() != exp_reads.size()) bad_at = 999;
        else for (int i = 0; i < exp_reads.size(); i++) if (bad_at < 0 && obs_reads[i] != exp_reads[i]) bad_at = i;
        checks++;
        if (bad_at >= 0) begin
            failures++;
            $display("FAIL %s reads: got %0d reads %p expected %0d reads %p", tag,
                     obs_reads.size(), obs_reads[0:((obs_reads.size() > 8) ? 7 : obs_reads.size() - 1)],
                     exp_reads.size(), exp_reads[0:((exp_reads.size() > 8) ? 7 : exp_reads.size() - 1)]);
        end
        checks++;
        if ({bus.cur_1_addr, bus.cur_2_addr, bus.cur_3_addr, bus.cur_4_addr} !==
            {AW'(ref_cur[0]), AW'(ref_cur[1]), AW'(ref_cur[2]), AW'(ref_cur[3])}) begin
            failures++;
            $display("FAIL %s cur: got %0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d", tag,
                     bus.cur_1_addr, bus.cur_2_addr, bus.cur_3_addr, bus.cur_4_addr,
                     ref_cur[0], ref_cur[1], ref_cur[2], ref_cur[3]);
        end
        tick();
        bad_at = -1;
        for (int a = 0; a < CELLS; a++) if (bad_at < 0 && mem[a] !== ref_mem[a]) bad_at = a;
        checks++;
        if (bad_at >= 0) begin
            failures++;
            $display("FAIL %s board: cell %0d got %h expected %h", tag, bad_at, mem[bad_at], ref_mem[bad_at]);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after_done: busy=%b expected 0", tag, bus.busy);
        end
        $display("step %s: latency=%0d landed=%0b writes=%0d cur=%0d,%0d,%0d,%0d", tag, lat, got_landed,
                 nwr, bus.cur_1_addr, bus.cur_2_addr, bus.cur_3_addr, bus.cur_4_addr);
    endtask

    task automatic test_reset;
        bus.load = 1'b0; bus.en = 1'b0; bus.piece_data = '0;
        bus.reg_1_addr = '0; bus.reg_2_addr = '0; bus.reg_3_addr = '0; bus.reg_4_addr = '0;
`ifdef DROPPER_HARD_DROP_EN
        bus.hard_drop = 1'b0;
`endif
        rst = 1'b1;
        @(negedge clk);
        clear_board();
        checks++;
        if ({bus.busy, bus.done, bus.landed, bus.we} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: busy/done/landed/we=%b expected 0000",
                     {bus.busy, bus.done, bus.landed, bus.we});
        end
        checks++;
        if ({bus.addr, bus.wdata} !== '0) begin
            failures++;
            $display("FAIL reset_bus: addr=%0d wdata=%h expected 0", bus.addr, bus.wdata);
        end
        checks++;
        if ({bus.cur_1_addr, bus.cur_2_addr, bus.cur_3_addr, bus.cur_4_addr} !== '0) begin
            failures++;
            $display("FAIL reset_cur: cur=%0d,%0d,%0d,%0d expected 0", bus.cur_1_addr, bus.cur_2_addr,
                     bus.cur_3_addr, bus.cur_4_addr);
        end
        rst = 1'b0;
        ref_valid = 1'b0;
        ref_cur = '{0, 0, 0, 0};
        tick();
        $display("reset: busy=%b done=%b we=%b addr=%0d", bus.busy, bus.done, bus.we, bus.addr);
        // No piece loaded yet: en must be ignored.
        run_step(1'b0, 1'b0, "en_before_load");
    endtask

    task automatic test_o_piece;
        clear_board();
        place(4, 5, 14, 15, 8'h03);
        run_step(1'b0, 1'b0, "o_move");
    endtask

    task automatic test_blocked;
        clear_board();
        place(4, 5, 14, 15, 8'h03);
        tb_put(25, 8'h01);
        run_step(1'b0, 1'b0, "o_blocked");
        run_step(1'b0, 1'b0, "after_landed");
    endtask

    task automatic test_bottom;
        clear_board();
        place(190, 191, 192, 193, 8'h05);
        run_step(1'b0, 1'b0, "bottom_row");
    endtask

    task automatic test_vertical_i;
        clear_board();
        place(4, 14, 24, 34, 8'h07);
        run_step(1'b0, 1'b0, "i_vertical");
    endtask

    task automatic test_reset_mid;
        clear_board();
        place(4, 5, 14, 15, 8'h03);
        bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
        repeat (6) tick();
        checks++;
        if ({bus.we, bus.addr} !== {1'b1, 8'd5}) begin
            failures++;
            $display("FAIL mid_erase2: we=%b addr=%0d expected we=1 addr=5", bus.we, bus.addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.we, bus.busy, bus.done} !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset: we=%b busy=%b done=%b expected 000", bus.we, bus.busy, bus.done);
        end
        $display("mid-step reset: we=%b busy=%b", bus.we, bus.busy);
        @(negedge clk);
        rst = 1'b0;
        ref_valid = 1'b0;
        ref_cur = '{0, 0, 0, 0};
        tick();
        run_step(1'b0, 1'b0, "en_after_reset");
    endtask

    task automatic test_load_en_same_cycle;
        bit busy_seen;
        clear_board();
        tb_put(4, 8'h09); tb_put(5, 8'h09); tb_put(14, 8'h09); tb_put(15, 8'h09);
        bus.reg_1_addr = 8'd4; bus.reg_2_addr = 8'd5; bus.reg_3_addr = 8'd14; bus.reg_4_addr = 8'd15;
        bus.piece_data = 8'h09;
        bus.load = 1'b1;
        bus.en = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.en = 1'b0;
        ref_cur = '{4, 5, 14, 15};
        ref_color = 8'h09;
        ref_valid = 1'b1;
        busy_seen = 1'b0;
        repeat (3) begin
            if (bus.busy) busy_seen = 1'b1;
            tick();
        end
        checks++;
        if (busy_seen !== 1'b0) begin
            failures++;
            $display("FAIL load_en_same_cycle: busy seen=%b expected 0", busy_seen);
        end
        run_step(1'b0, 1'b0, "after_load_en");
    endtask

    task automatic test_random;
        for (int it = 0; it < 12; it++) begin
            int s, base, nsteps;
            logic [DW-1:0] col;
            bit hd;
            clear_board();
            for (int a = 0; a < CELLS; a++) begin
                if ($urandom_range(0, 7) == 0) tb_put(a, DW'($urandom_range(1, 255)));
            end
            s = $urandom_range(0, 6);
            base = $urandom_range(0, 16) * BOARD_W + $urandom_range(0, BOARD_W - wid[s]);
            col = DW'($urandom_range(1, 255));
            place(base + offs[s][0], base + offs[s][1], base + offs[s][2], base + offs[s][3], col);
            nsteps = $urandom_range(1, 4);
            for (int st = 0; st < nsteps; st++) begin
                hd = 1'b0;
`ifdef DROPPER_HARD_DROP_EN
                hd = ($urandom_range(0, 3) == 0);
`endif
                run_step(hd, 1'($urandom_range(0, 1)), "random");
            end
        end
    endtask

`ifdef DROPPER_HARD_DROP_EN
    task automatic test_hard_drop;
        clear_board();
        place(4, 5, 14, 15, 8'h03);
        run_step(1'b1, 1'b0, "hard_drop");
        checks++;
        if ({bus.cur_1_addr, bus.cur_2_addr, bus.cur_3_addr, bus.cur_4_addr} !==
            {8'd184, 8'd185, 8'd194, 8'd195}) begin
            failures++;
            $display("FAIL hard_drop_final: cur=%0d,%0d,%0d,%0d expected 184,185,194,195",
                     bus.cur_1_addr, bus.cur_2_addr, bus.cur_3_addr, bus.cur_4_addr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_o_piece();
        test_blocked();
        test_bottom();
        test_vertical_i();
        test_reset_mid();
        test_load_en_same_cycle();
`ifdef DROPPER_HARD_DROP_EN
        test_hard_drop();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
